// File: rtl/uart_phy.sv
// 8N1 UART physical layer: independent receiver and transmitter sharing one
// baud divisor DIV = CLK_FREQ/UART_FREQ.
module uart_phy #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_finished,
    output logic       dbg_rx_enable,
    output logic       dbg_tx_enable
);

    localparam int DIV = CLK_FREQ / UART_FREQ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic          rx_meta_q, rx_sync_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          rx_err_q, rx_err_d;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_fin_q, tx_fin_d;

    // Receiver: start detected, then sampled mid-bit via a half-period offset.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter: tx_d always holds the level of the bit that starts next edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_fin_d   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_write) begin
                    tx_shift_d = tx_data;
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_fin_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_fin_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            rx_err_q   <= rx_err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_fin_q   <= tx_fin_d;
        end
    end

    assign tx            = tx_q;
    assign rx_ready      = rx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_frame_err  = rx_err_q;
    assign tx_finished   = tx_fin_q;
    assign dbg_rx_enable = (rx_state_q != RX_IDLE);
    assign dbg_tx_enable = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy at DIV=104: RX vector table, TX waveform
// model, directed corner cases and a randomized full-duplex phase.
module tb_uart_phy;

    localparam int DIV = 12000000 / 115200;

    logic       clk = 1'b0;
    logic       n_reset, rx, tx, rx_ready, rx_frame_err;
    logic       tx_write, tx_finished, dbg_rx_enable, dbg_tx_enable;
    logic [7:0] rx_data, tx_data;

    int vectors = 0;
    int miscompares = 0;
    int rdy_cnt = 0, err_cnt = 0, fin_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] model_rx_data;

    always #5 clk = ~clk;

    uart_phy #(.CLK_FREQ(12000000), .UART_FREQ(115200)) dut (
        .clk(clk), .n_reset(n_reset), .rx(rx), .tx(tx),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .tx_write(tx_write), .tx_data(tx_data), .tx_finished(tx_finished),
        .dbg_rx_enable(dbg_rx_enable), .dbg_tx_enable(dbg_tx_enable)
    );

    always @(negedge clk) begin
        if (rx_ready === 1'b1) begin
            rdy_cnt++;
            rx_q.push_back(rx_data);
        end
        if (rx_frame_err === 1'b1) err_cnt++;
        if (tx_finished === 1'b1) fin_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one 8N1 frame on rx starting at a negedge.
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = f[b];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic rx_frame_check(input logic [7:0] d, input logic stop);
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_rx(d, stop);
        repeat (DIV) @(negedge clk);
        if (stop) model_rx_data = d;
        check($sformatf("rx_ready_count[%02h]", d), rdy_cnt - r0, stop ? 1 : 0);
        check($sformatf("rx_err_count[%02h]", d), err_cnt - e0, stop ? 0 : 1);
        check($sformatf("rx_data[%02h]", d), rx_data, model_rx_data);
        check("rx_queue_size", rx_q.size(), stop ? 1 : 0);
        if (rx_q.size() > 0) check("rx_byte_at_pulse", rx_q.pop_front(), d);
    endtask

    // Checks the tx waveform cycle by cycle from the negedge after acceptance
    // (k=0) through the tx_finished cycle (k=10*DIV).
    task automatic tx_frame(input logic [7:0] d, input logic inject);
        logic [9:0] f;
        logic       bad;
        logic [2:0] got;
        int         k;
        f = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            got = 3'b000;
            for (int c = 0; c < DIV; c++) begin
                k = b * DIV + c;
                if (inject && k == 5 * DIV + 3) begin
                    tx_write = 1'b1;
                    tx_data  = 8'hFF;
                end else if (inject && k == 5 * DIV + 4) begin
                    tx_write = 1'b0;
                end
                if (!bad && (tx !== f[b] || tx_finished !== 1'b0 || dbg_tx_enable !== 1'b1)) begin
                    bad = 1'b1;
                    got = {tx, tx_finished, dbg_tx_enable};
                end
                @(negedge clk);
            end
            check($sformatf("tx_bit%0d[%02h] {tx,fin,en}", b, d),
                  bad ? got : {f[b], 1'b0, 1'b1}, {f[b], 1'b0, 1'b1});
        end
        check($sformatf("tx_finished[%02h]", d), tx_finished, 1'b1);
        check($sformatf("tx_stop_level[%02h]", d), tx, 1'b1);
        check($sformatf("dbg_tx_idle[%02h]", d), dbg_tx_enable, 1'b0);
    endtask

    task automatic tx_send(input logic [7:0] d, input logic inject);
        tx_write = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_write = 1'b0;
        tx_frame(d, inject);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_ready;
        int         exp_err;
    } rx_vec_t;

    rx_vec_t tbl[6];

    initial begin
        int r0, e0, f0;
        tbl = '{'{8'h3C, 1'b1, 8'h3C, 1, 0},
                '{8'h55, 1'b0, 8'h3C, 0, 1},
                '{8'h00, 1'b1, 8'h00, 1, 0},
                '{8'hFF, 1'b1, 8'hFF, 1, 0},
                '{8'hA5, 1'b0, 8'hFF, 0, 1},
                '{8'h81, 1'b1, 8'h81, 1, 0}};

        n_reset = 1'b0; rx = 1'b1; tx_write = 1'b0; tx_data = 8'h00;
        model_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_rx_ready", rx_ready, 1'b0);
        check("reset_rx_err", rx_frame_err, 1'b0);
        check("reset_tx_finished", tx_finished, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_dbg", {dbg_rx_enable, dbg_tx_enable}, 2'b00);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);

        // RX table: good frames, framing errors, recovery after error.
        foreach (tbl[i]) begin
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_rx(tbl[i].data, tbl[i].stop);
            repeat (DIV) @(negedge clk);
            check($sformatf("tbl%0d_ready", i), rdy_cnt - r0, tbl[i].exp_ready);
            check($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_err);
            check($sformatf("tbl%0d_rx_data", i), rx_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_dbg_rx", i), dbg_rx_enable, 1'b0);
        end
        rx_q.delete();
        model_rx_data = 8'h81;

        // Short low glitch on rx is rejected.
        r0 = rdy_cnt; e0 = err_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_dbg_rx_busy", dbg_rx_enable, 1'b1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
        check("glitch_no_ready", rdy_cnt - r0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_dbg_rx_idle", dbg_rx_enable, 1'b0);
        check("glitch_rx_data_kept", rx_data, 8'h81);

        // TX frames, including one with an ignored mid-frame write followed
        // by a write in the tx_finished cycle.
        f0 = fin_cnt;
        tx_send(8'hA5, 1'b0);
        repeat (3) @(negedge clk);
        check("tx_finished_one_pulse", fin_cnt - f0, 1);
        check("tx_idle_high", tx, 1'b1);
        tx_send(8'h00, 1'b1);
        tx_send(8'h12, 1'b0);
        repeat (3) @(negedge clk);
        check("tx_idle_after_chain", {tx, dbg_tx_enable}, 2'b10);

        // Reset mid-TX and mid-RX, with rx held low through reset.
        tx_write = 1'b1; tx_data = 8'hC3;
        @(negedge clk);
        tx_write = 1'b0;
        rx = 1'b0;
        repeat (250) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        check("pre_reset_busy", {dbg_rx_enable, dbg_tx_enable}, 2'b11);
        n_reset = 1'b0;
        rx = 1'b0;
        @(negedge clk);
        check("midreset_tx", tx, 1'b1);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_dbg", {dbg_rx_enable, dbg_tx_enable}, 2'b00);
        check("midreset_pulses", {rx_ready, rx_frame_err, tx_finished}, 3'b000);
        repeat (3) @(negedge clk);
        r0 = rdy_cnt; e0 = err_cnt; f0 = fin_cnt;
        n_reset = 1'b1;
        @(negedge clk);
        check("post_release_rx_idle", dbg_rx_enable, 1'b0);
        repeat (4) @(negedge clk);
        check("low_line_starts_rx", dbg_rx_enable, 1'b1);
        rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        check("aborted_no_pulses", {rdy_cnt - r0, err_cnt - e0, fin_cnt - f0}, 96'd0);
        check("aborted_tx_high", {tx, dbg_tx_enable, dbg_rx_enable}, 3'b100);
        rx_q.delete();
        model_rx_data = 8'h00;
        rx_frame_check(8'h6E, 1'b1);

        // Randomized full duplex against the frame-level model.
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    tx_send(8'($urandom), 1'b0);
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < 4; n++) begin
                    logic [7:0] d;
                    logic       s;
                    d = 8'($urandom);
                    s = ($urandom_range(0, 3) != 0);
                    rx_frame_check(d, s);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
